// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: per-register in-flight write scoreboard driving ID stalls and EX redirect flushes
// Ports: clk; rst_n (synchronous, active-low); id_instr/id_reg_write/id_reg_dst decoded ID instruction;
//   wb_we/wb_rd register-file write port; ex_redirect taken branch/jump from EX;
//   pc_stall/ifid_stall hold fetch, ifid_flush squash IF/ID, idex_flush bubble ID/EX, sb_busy any write in flight.
// Optional macro SB_STALL_PERF_EN adds stall_cycles/redirect_cycles 32-bit event counters.
module id_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_instr,
    input  logic        id_reg_write,
    input  logic        id_reg_dst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic        ex_redirect,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        sb_busy
`ifdef SB_STALL_PERF_EN
   ,output logic [31:0] stall_cycles,
    output logic [31:0] redirect_cycles
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:1] inc, dec, busy_vec;
    logic [5:0]          opcode;
    logic [4:0]          rs, rt, dest;
    logic                uses_rs, uses_rt, hazard, issue;
    logic                unused_bits;
    assign opcode      = id_instr[31:26];
    assign rs          = id_instr[25:21];
    assign rt          = id_instr[20:16];
    assign dest        = id_reg_dst ? id_instr[15:11] : rt;
    assign unused_bits = ^id_instr[10:0];
    // R-type, branches and stores read rt; jumps read nothing; everything else reads rs only
    assign uses_rt = opcode inside {6'h00, 6'h04, 6'h05, 6'h2b};
    assign uses_rs = !(opcode inside {6'h02, 6'h03});
    assign hazard  = (uses_rs && cnt[rs] != '0) || (uses_rt && cnt[rt] != '0);
    assign issue   = !ex_redirect && !hazard;
    assign pc_stall   = !ex_redirect && hazard;
    assign ifid_stall = !ex_redirect && hazard;
    assign ifid_flush = ex_redirect;
    assign idex_flush = ex_redirect || hazard;
    assign sb_busy    = |busy_vec;
    // a WB to an idle register is ignored so spurious writes cannot underflow
    always_comb begin
        inc      = '0;
        dec      = '0;
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r]      = issue && id_reg_write && dest == 5'(r);
            dec[r]      = wb_we && wb_rd == 5'(r) && cnt[r] != '0;
            busy_vec[r] = cnt[r] != '0;
        end
    end
    always_ff @(posedge clk) begin
        cnt[0] <= '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (!rst_n)
                cnt[r] <= '0;
            else if (inc[r] && !dec[r] && cnt[r] != CNT_MAX)
                cnt[r] <= cnt[r] + CNT_W'(1);
            else if (dec[r] && !inc[r])
                cnt[r] <= cnt[r] - CNT_W'(1);
        end
    end
`ifdef SB_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles    <= '0;
            redirect_cycles <= '0;
        end else begin
            if (ex_redirect)
                redirect_cycles <= redirect_cycles + 32'd1;
            if (!ex_redirect && hazard)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: directed vector table, hand sequences and randomized pipeline traffic vs a pending-write list model
module tb_id_hazard_scoreboard;
    localparam logic [31:0] ADD3  = 32'h00221820;
    localparam logic [31:0] SUB4  = 32'h00652022;
    localparam logic [31:0] OR6   = 32'h00E83025;
    localparam logic [31:0] ADDI0 = 32'h20200005;
    localparam logic [31:0] JMP   = 32'h08000000;
    localparam logic [31:0] ADD2  = 32'h00211020;
    localparam logic [31:0] ADD5  = 32'h00212820;
    logic        clk = 1'b0;
    logic        rst_n, id_reg_write, id_reg_dst, wb_we, ex_redirect;
    logic [31:0] id_instr;
    logic [4:0]  wb_rd;
    logic        pc_stall, ifid_stall, ifid_flush, idex_flush, sb_busy;
`ifdef SB_STALL_PERF_EN
    logic [31:0] stall_cycles, redirect_cycles;
`endif
    int checks = 0;
    int errors = 0;
    int pend[$];
    int m_stall = 0;
    int m_red = 0;
    int ex_d = 0;
    int mem_d = 0;
    int wb_d = 0;
    logic [5:0] ops [8] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h2b, 6'h23, 6'h08};
    // ctl = {reg_write, reg_dst, wb_we, ex_redirect, rst_n}; exp = {pc_stall, ifid_stall, ifid_flush, idex_flush, sb_busy}
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  ctl;
        logic [4:0]  rd;
        logic [4:0]  exp;
    } vec_t;
    vec_t vecs [23];

    always #5 clk = ~clk;

    id_hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_reg_write(id_reg_write),
        .id_reg_dst(id_reg_dst), .wb_we(wb_we), .wb_rd(wb_rd), .ex_redirect(ex_redirect),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .sb_busy(sb_busy)
`ifdef SB_STALL_PERF_EN
       ,.stall_cycles(stall_cycles), .redirect_cycles(redirect_cycles)
`endif
    );

    // a counter at its ceiling must never see an unmatched increment
    always @(posedge clk)
        if (rst_n)
            for (int r = 1; r < 32; r++)
                assert (!(dut.inc[r] && !dut.dec[r] && dut.cnt[r] == 2'd3))
                    else $error("FAIL saturation reg %0d", r);

    function automatic int inflight(int r);
        int n = 0;
        foreach (pend[i]) if (pend[i] == r) n++;
        return n;
    endfunction

    function automatic bit m_hazard();
        logic [5:0] op;
        bit urs, urt;
        op  = id_instr[31:26];
        urt = op inside {6'h00, 6'h04, 6'h05, 6'h2b};
        urs = !(op inside {6'h02, 6'h03});
        return (urs && inflight(int'(id_instr[25:21])) > 0) || (urt && inflight(int'(id_instr[20:16])) > 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic rw, input logic dst, input logic we,
                         input logic [4:0] rd, input logic red, input logic rn);
        id_instr = i; id_reg_write = rw; id_reg_dst = dst; wb_we = we; wb_rd = rd;
        ex_redirect = red; rst_n = rn;
    endtask

    task automatic model_check();
        bit h;
        h = m_hazard();
        check("pc_stall", pc_stall, !ex_redirect && h);
        check("ifid_stall", ifid_stall, !ex_redirect && h);
        check("ifid_flush", ifid_flush, ex_redirect);
        check("idex_flush", idex_flush, ex_redirect || h);
        check("sb_busy", sb_busy, pend.size() != 0);
`ifdef SB_STALL_PERF_EN
        check("stall_cycles", stall_cycles, 32'(m_stall));
        check("redirect_cycles", redirect_cycles, 32'(m_red));
`endif
    endtask

    task automatic model_edge();
        bit h;
        int d;
        int q[$];
        h = m_hazard();
        d = id_reg_dst ? int'(id_instr[15:11]) : int'(id_instr[20:16]);
        if (!rst_n) begin
            pend.delete();
            m_stall = 0;
            m_red = 0;
        end else begin
            if (ex_redirect) m_red++;
            else if (h) m_stall++;
            if (wb_we) begin
                q = pend.find_first_index(x) with (x == int'(wb_rd));
                if (q.size() > 0) pend.delete(q[0]);
            end
            if (!ex_redirect && !h && id_reg_write && d != 0) pend.push_back(d);
        end
    endtask

    task automatic tick(input bit chk);
        #4;
        if (chk) model_check();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        drive(vecs[i].instr, vecs[i].ctl[4], vecs[i].ctl[3], vecs[i].ctl[2], vecs[i].rd,
              vecs[i].ctl[1], vecs[i].ctl[0]);
    endtask

    initial begin
        vecs[0]  = '{ADD3,  5'b11001, 5'd0, 5'b00000};
        vecs[1]  = '{SUB4,  5'b11001, 5'd0, 5'b11011};
        vecs[2]  = '{SUB4,  5'b11001, 5'd0, 5'b11011};
        vecs[3]  = '{SUB4,  5'b11101, 5'd3, 5'b11011};
        vecs[4]  = '{SUB4,  5'b11001, 5'd0, 5'b00000};
        vecs[5]  = '{OR6,   5'b11001, 5'd0, 5'b00001};
        vecs[6]  = '{ADDI0, 5'b10001, 5'd0, 5'b00001};
        vecs[7]  = '{JMP,   5'b00101, 5'd4, 5'b00001};
        vecs[8]  = '{JMP,   5'b00101, 5'd6, 5'b00001};
        vecs[9]  = '{JMP,   5'b00001, 5'd0, 5'b00000};
        vecs[10] = '{JMP,   5'b00101, 5'd9, 5'b00000};
        vecs[11] = '{JMP,   5'b00001, 5'd0, 5'b00000};
        vecs[12] = '{ADD3,  5'b11001, 5'd0, 5'b00000};
        vecs[13] = '{SUB4,  5'b11011, 5'd0, 5'b00111};
        vecs[14] = '{SUB4,  5'b11001, 5'd0, 5'b11011};
        vecs[15] = '{SUB4,  5'b11101, 5'd3, 5'b11011};
        vecs[16] = '{JMP,   5'b00001, 5'd0, 5'b00000};
        vecs[17] = '{ADD2,  5'b11001, 5'd0, 5'b00000};
        vecs[18] = '{ADD2,  5'b11001, 5'd0, 5'b00001};
        vecs[19] = '{JMP,   5'b00000, 5'd0, 5'b00001};
        vecs[20] = '{JMP,   5'b00001, 5'd0, 5'b00000};
        vecs[21] = '{JMP,   5'b00010, 5'd0, 5'b00110};
        vecs[22] = '{JMP,   5'b00001, 5'd0, 5'b00000};
        drive(JMP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset pc_stall", pc_stall, 0);
        check("reset ifid_stall", ifid_stall, 0);
        check("reset ifid_flush", ifid_flush, 0);
        check("reset idex_flush", idex_flush, 0);
        check("reset sb_busy", sb_busy, 0);
        for (int i = 0; i < 23; i++) begin
            apply_vec(i);
            #4;
            check($sformatf("vec%0d pc_stall", i), pc_stall, vecs[i].exp[4]);
            check($sformatf("vec%0d ifid_stall", i), ifid_stall, vecs[i].exp[3]);
            check($sformatf("vec%0d ifid_flush", i), ifid_flush, vecs[i].exp[2]);
            check($sformatf("vec%0d idex_flush", i), idex_flush, vecs[i].exp[1]);
            check($sformatf("vec%0d sb_busy", i), sb_busy, vecs[i].exp[0]);
            model_edge();
            @(posedge clk);
            #1;
        end
        drive(ADD5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); tick(1);
        drive(ADD5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1); tick(1);
        check("two writers cnt5", dut.cnt[5], 2);
        drive(JMP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1); tick(1);
        drive(ADD5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1); tick(1);
        check("inc+dec cnt5", dut.cnt[5], 2);
        drive(JMP, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1); tick(1);
        check("drain1 cnt5", dut.cnt[5], 1);
        drive(JMP, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1); tick(1);
        check("drain2 cnt5", dut.cnt[5], 0);
        check("drain sb_busy", sb_busy, 0);
`ifdef SB_STALL_PERF_EN
        drive(JMP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(0);
        for (int i = 0; i < 5; i++) begin
            apply_vec(i);
            tick(1);
        end
        drive(JMP, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b1); tick(1);
        check("perf stall_cycles", stall_cycles, 3);
        check("perf redirect_cycles", redirect_cycles, 1);
`endif
        drive(JMP, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); tick(0);
        for (int n = 0; n < 3000; n++) begin
            bit h;
            int d, r, nxt;
            drive({ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 5'd0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) != 0);
            if (wb_d != 0) begin
                wb_we = 1'b1;
                wb_rd = 5'(wb_d);
            end else if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(1, 7);
                if (inflight(r) == 0) begin
                    wb_we = 1'b1;
                    wb_rd = 5'(r);
                end
            end
            h = m_hazard();
            d = id_reg_dst ? int'(id_instr[15:11]) : int'(id_instr[20:16]);
            nxt = (rst_n && !ex_redirect && !h && id_reg_write) ? d : 0;
            tick(1);
            if (!rst_n) begin
                ex_d = 0; mem_d = 0; wb_d = 0;
            end else begin
                wb_d = mem_d; mem_d = ex_d; ex_d = nxt;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
